j_result_deserializer: RTL and testbench

Downstream of j_systolic_array. Consumes its bit-serial per-lane accumulation outputs (result/result_en, 4*SUBARRAY_HEIGHT lanes, LSB-first). Per lane it:
- rebuilds the W_ACC-bit two's-complement word;
- applies ReLU, right-shift and saturation to W_OUT bits;
- holds the word until every lane has a word, then presents one lane-parallel vector on a valid/ready interface to the next layer's buffer.

---
 rtl/j_pkg.sv | 36 +++
 rtl/j_deser_lane.sv | 72 +++++++
 rtl/j_result_deserializer.sv | 58 +++++
 tb/tb_j_result_deserializer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/j_pkg.sv
// Shared types and helpers for the systolic-array result deserializer.
// Optional rounding in quantize() is enabled by defining J_DESER_ROUND_EN.
package j_pkg;

    localparam int J_W_ACC_DEF = 16;
    localparam int J_W_OUT_DEF = 8;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    // ReLU, right-shift (clamped to w_acc-1) and unsigned saturation to w_out bits.
    // Working width is 64 bits so the rounding add can never wrap.
    function automatic logic [31:0] quantize(input logic signed [63:0] acc,
                                             input int                 sh,
                                             input int                 w_acc,
                                             input int                 w_out);
        logic signed [63:0] s;
        logic signed [63:0] lim;
        int                 sh_e;
        sh_e = (sh > w_acc - 1) ? w_acc - 1 : sh;
        lim  = (64'sd1 <<< w_out) - 64'sd1;
        if (acc < 0) return '0;
`ifdef J_DESER_ROUND_EN
        if (sh_e > 0) s = (acc + (64'sd1 <<< (sh_e - 1))) >>> sh_e;
        else          s = acc;
`else
        s = acc >>> sh_e;
`endif
        return (s > lim) ? lim[31:0] : s[31:0];
    endfunction

endpackage

// File: rtl/j_deser_lane.sv
// One deserializer lane: LSB-first bit collection, quantization at word
// completion, a single-entry hold and a drop pulse when the hold is occupied.
module j_deser_lane
    import j_pkg::*;
#(
    parameter int W_ACC   = J_W_ACC_DEF,
    parameter int W_OUT   = J_W_OUT_DEF,
    parameter int W_SHIFT = clog2(W_ACC)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               bit_i,
    input  logic               en_i,
    input  logic [W_SHIFT-1:0] shift_amt_i,
    input  logic               clr_i,
    output logic [W_OUT-1:0]   hold_o,
    output logic               hold_vld_o,
    output logic               drop_o
);

    localparam int CNT_W = clog2(W_ACC);

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [W_ACC-2:0]        sr_q, sr_d;
    logic signed [W_ACC-1:0] word_w;
    logic                    done_w;
    logic [W_OUT-1:0]        q_w;
    logic [W_OUT-1:0]        hold_q, hold_d;
    logic                    vld_q, vld_d;

    always_comb begin
        done_w = en_i && (cnt_q == CNT_W'(W_ACC - 1));
        // The newest bit lands at the MSB; earlier bits have already shifted down.
        word_w = {bit_i, sr_q};
        sr_d   = sr_q;
        cnt_d  = cnt_q;
        if (en_i) begin
            sr_d  = word_w[W_ACC-1:1];
            cnt_d = done_w ? '0 : cnt_q + CNT_W'(1);
        end
        q_w = W_OUT'(quantize(64'(word_w), int'(shift_amt_i), W_ACC, W_OUT));

        hold_d = hold_q;
        vld_d  = vld_q;
        drop_o = 1'b0;
        if (done_w && (!vld_q || clr_i)) begin
            hold_d = q_w;
            vld_d  = 1'b1;
        end else if (done_w) begin
            drop_o = 1'b1;
        end else if (clr_i) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        sr_q <= sr_d;
        if (reset) begin
            cnt_q  <= '0;
            hold_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            hold_q <= hold_d;
            vld_q  <= vld_d;
        end
    end

    assign hold_o     = hold_q;
    assign hold_vld_o = vld_q;

endmodule

// File: rtl/j_result_deserializer.sv
// Lane-parallel deserializer for j_systolic_array serial results with a
// valid/ready output. Define J_DESER_ROUND_EN for round-half-up quantization.
module j_result_deserializer
    import j_pkg::*;
#(
    parameter  int SUBARRAY_HEIGHT = 32,
    parameter  int W_ACC           = J_W_ACC_DEF,
    parameter  int W_OUT           = J_W_OUT_DEF,
    parameter  int W_SHIFT         = clog2(W_ACC),
    localparam int NUM_LANES       = 4 * SUBARRAY_HEIGHT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_LANES-1:0]       result,
    input  logic [NUM_LANES-1:0]       result_en,
    input  logic [W_SHIFT-1:0]         shift_amt,
    output logic [NUM_LANES*W_OUT-1:0] out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       overflow
);

    logic [NUM_LANES-1:0] hold_vld_w;
    logic [NUM_LANES-1:0] drop_w;
    logic                 xfer_w;
    logic                 overflow_q, overflow_d;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        j_deser_lane #(
            .W_ACC   (W_ACC),
            .W_OUT   (W_OUT),
            .W_SHIFT (W_SHIFT)
        ) u_lane (
            .clk         (clk),
            .reset       (reset),
            .bit_i       (result[i]),
            .en_i        (result_en[i]),
            .shift_amt_i (shift_amt),
            .clr_i       (xfer_w),
            .hold_o      (out_data[i*W_OUT +: W_OUT]),
            .hold_vld_o  (hold_vld_w[i]),
            .drop_o      (drop_w[i])
        );
    end

    // Holds are flops, so the vector is valid the cycle after the last lane fills.
    assign out_valid  = &hold_vld_w;
    assign xfer_w     = out_valid & out_ready;
    assign overflow_d = overflow_q | (|drop_w);

    always_ff @(posedge clk) begin
        if (reset) overflow_q <= 1'b0;
        else       overflow_q <= overflow_d;
    end

    assign overflow = overflow_q;

endmodule

// File: tb/tb_j_result_deserializer.sv
// Scoreboard bench for j_result_deserializer: serial words in, quantized vectors out.
module tb_j_result_deserializer;

    localparam int NL = 128;
    localparam int WO = 8;
    localparam int WS = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [NL-1:0]    result;
    logic [NL-1:0]    result_en;
    logic [WS-1:0]    shift_amt;
    logic [NL*WO-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             overflow;

    always #5 clk = ~clk;

    j_result_deserializer dut (
        .clk       (clk),
        .reset     (reset),
        .result    (result),
        .result_en (result_en),
        .shift_amt (shift_amt),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow)
    );

    int               vectors     = 0;
    int               miscompares = 0;
    logic [NL*WO-1:0] sb_q[$];
    logic [NL*WO-1:0] exp_v;
    logic [15:0]      wv [NL];
    int               st [NL];
    int               gp [NL];
    bit               act[NL];
    bit               early_valid;

    function automatic logic [7:0] q_model(input logic [15:0] w, input int sh);
        int a, s;
        a = int'(signed'(w));
        if (a < 0) return 8'h00;
        if (sh > 15) sh = 15;
`ifdef J_DESER_ROUND_EN
        if (sh > 0) s = (a + (1 << (sh - 1))) >>> sh;
        else        s = a;
`else
        s = a >>> sh;
`endif
        return (s > 255) ? 8'hFF : s[7:0];
    endfunction

    function automatic logic [NL*WO-1:0] exp_vec(input int sh);
        logic [NL*WO-1:0] v;
        for (int i = 0; i < NL; i++) v[i*WO +: WO] = q_model(wv[i], sh);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_all(input logic [15:0] w);
        for (int i = 0; i < NL; i++) begin
            wv[i] = w; st[i] = 0; gp[i] = 0; act[i] = 1'b1;
        end
    endtask

    // Drives nbits of each active lane's word, LSB first, honouring start offsets and gaps.
    task automatic send(input int nbits, input logic [3:0] sh);
        int k[NL];
        int cyc;
        bit busy;
        for (int i = 0; i < NL; i++) k[i] = act[i] ? 0 : nbits;
        early_valid = 1'b0;
        cyc  = 0;
        busy = 1'b1;
        while (busy && cyc < 3000) begin
            busy = 1'b0;
            for (int i = 0; i < NL; i++) begin
                result_en[i] = act[i] && (cyc >= st[i]) && (k[i] < nbits) &&
                               ($urandom_range(99) >= gp[i]);
                result[i]    = (k[i] < 16) ? wv[i][k[i]] : 1'b0;
                if (result_en[i]) k[i]++;
                if (k[i] < nbits) busy = 1'b1;
            end
            shift_amt = sh;
            if (busy && out_valid) early_valid = 1'b1;
            tick();
            cyc++;
        end
        result_en = '0;
        result    = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; result = '0; result_en = '0; shift_amt = '0; out_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_valid got=%b want=0", out_valid);
        end
        vectors++;
        if (out_data !== '0) begin
            miscompares++; $display("FAIL reset_data got=%h want=0", out_data[63:0]);
        end
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++; $display("FAIL reset_overflow got=%b want=0", overflow);
        end
    endtask

    task automatic test_basic();
        cfg_all(16'h0050);
        out_ready = 1'b1;
        sb_q.push_back(exp_vec(2));
        send(16, 4'd2);
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++; $display("FAIL basic_valid got=%b want=1", out_valid);
        end
        exp_v = sb_q.pop_front();
        vectors++;
        if (out_data !== exp_v || out_data[127*WO +: WO] !== 8'h14) begin
            miscompares++;
            $display("FAIL basic_data got=%h want=%h lane127=%h want=14",
                     out_data[63:0], exp_v[63:0], out_data[127*WO +: WO]);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL basic_valid_drop got=%b want=0", out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_sat_relu();
        cfg_all(16'h0003);
        wv[0] = 16'hFF00;
        wv[1] = 16'h1234;
        sb_q.push_back(exp_vec(0));
        send(16, 4'd0);
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++; $display("FAIL satrelu_valid got=%b want=1", out_valid);
        end
        exp_v = sb_q.pop_front();
        vectors++;
        if (out_data !== exp_v ||
            out_data[23:0] !== 24'h03FF00) begin
            miscompares++;
            $display("FAIL satrelu_data lanes2..0 got=%h want=03ff00 full=%h want=%h",
                     out_data[23:0], out_data[63:0], exp_v[63:0]);
        end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL satrelu_clear got=%b want=0", out_valid);
        end
    endtask

    task automatic test_skew_hold();
        logic [NL*WO-1:0] snap;
        bit               stable;
        cfg_all(16'h0000);
        for (int i = 0; i < NL; i++) begin
            wv[i] = 16'($urandom_range(65535));
            st[i] = (i == 5) ? 0 : 6;
            gp[i] = (i == 5) ? 0 : 30;
        end
        sb_q.push_back(exp_vec(3));
        send(16, 4'd3);
        vectors++;
        if (early_valid !== 1'b0) begin
            miscompares++; $display("FAIL skew_early_valid got=%b want=0", early_valid);
        end
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++; $display("FAIL skew_valid got=%b want=1", out_valid);
        end
        exp_v = sb_q.pop_front();
        vectors++;
        if (out_data !== exp_v) begin
            miscompares++; $display("FAIL skew_data got=%h want=%h", out_data[63:0], exp_v[63:0]);
        end
        snap   = out_data;
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (out_data !== snap || out_valid !== 1'b1) stable = 1'b0;
        end
        vectors++;
        if (stable !== 1'b1) begin
            miscompares++; $display("FAIL skew_stall_stable got=%b want=1", stable);
        end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL skew_clear got=%b want=0", out_valid);
        end
    endtask

    task automatic test_overflow();
        logic [NL*WO-1:0] first;
        cfg_all(16'h0000);
        for (int i = 0; i < NL; i++) wv[i] = 16'($urandom_range(65535));
        sb_q.push_back(exp_vec(1));
        send(16, 4'd1);
        first = sb_q.pop_front();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== first) begin
            miscompares++;
            $display("FAIL ovf_first got=%b/%h want=1/%h", out_valid, out_data[63:0], first[63:0]);
        end
        for (int i = 0; i < NL; i++) act[i] = (i == 3);
        wv[3] = 16'h0040;
        send(16, 4'd0);
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++; $display("FAIL ovf_set got=%b want=1", overflow);
        end
        vectors++;
        if (out_data !== first) begin
            miscompares++;
            $display("FAIL ovf_hold got=%h want=%h", out_data[63:0], first[63:0]);
        end
        repeat (3) tick();
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++; $display("FAIL ovf_sticky got=%b want=1", overflow);
        end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        cfg_all(16'h0000);
        for (int i = 0; i < NL; i++) wv[i] = 16'($urandom_range(65535));
        wv[3] = 16'h0021;
        sb_q.push_back(exp_vec(0));
        send(16, 4'd0);
        exp_v = sb_q.pop_front();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== exp_v || out_data[3*WO +: WO] !== 8'h21) begin
            miscompares++;
            $display("FAIL ovf_reframe got=%b/%h want=1/%h lane3=%h want=21",
                     out_valid, out_data[63:0], exp_v[63:0], out_data[3*WO +: WO]);
        end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_reset_midword();
        cfg_all(16'hFFFF);
        send(7, 4'd0);
        reset = 1'b1; tick(); reset = 1'b0;
        repeat (2) tick();
        vectors++;
        if (out_valid !== 1'b0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_state valid=%b ovf=%b want=0/0", out_valid, overflow);
        end
        cfg_all(16'h0010);
        out_ready = 1'b1;
        sb_q.push_back(exp_vec(0));
        send(16, 4'd0);
        exp_v = sb_q.pop_front();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== exp_v || out_data[7:0] !== 8'h10) begin
            miscompares++;
            $display("FAIL midrst_word got=%b/%h want=1/%h", out_valid, out_data[63:0], exp_v[63:0]);
        end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_round();
        logic [7:0] want;
`ifdef J_DESER_ROUND_EN
        want = 8'h02;
`else
        want = 8'h01;
`endif
        out_ready = 1'b1;
        cfg_all(16'h0006);
        sb_q.push_back(exp_vec(2));
        send(16, 4'd2);
        exp_v = sb_q.pop_front();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== exp_v || out_data[9*WO +: WO] !== want) begin
            miscompares++;
            $display("FAIL round_6_sh2 got=%b/%h want=1/%h", out_valid, out_data[9*WO +: WO], want);
        end
        tick();
`ifdef J_DESER_ROUND_EN
        want = 8'h01;
`else
        want = 8'h00;
`endif
        cfg_all(16'h7FFF);
        sb_q.push_back(exp_vec(15));
        send(16, 4'd15);
        exp_v = sb_q.pop_front();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== exp_v || out_data[7:0] !== want) begin
            miscompares++;
            $display("FAIL round_7fff_sh15 got=%b/%h want=1/%h", out_valid, out_data[7:0], want);
        end
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sat_relu();
        test_skew_hold();
        test_overflow();
        test_reset_midword();
        test_round();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
